// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry pipeline register toward execute, with an
// internal 32x32 register file, writeback bypass and operand refresh while stalled.
module decode_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic        id_funct7_b5,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic        id_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] rf [32];
    logic        accept;
    logic        wb_write;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        dec_illegal;
    logic [31:0] rs1_val, rs2_val;

    assign if_ready = !flush && (!id_valid || id_ready);
    assign accept   = if_valid && if_ready;
    assign wb_write = wb_en && (wb_rd != 5'd0);

    assign opc = if_instr[6:0];
    assign f3  = if_instr[14:12];
    assign f7  = if_instr[31:25];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'd0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    always_comb begin
        dec_illegal = 1'b0;
        dec_imm     = 32'd0;
        dec_rd      = if_instr[11:7];
        dec_rs1     = if_instr[19:15];
        dec_rs2     = 5'd0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec_rs1 = 5'd0;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                dec_rs1 = 5'd0;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                dec_illegal = (f3 != 3'b000);
                dec_imm     = imm_i;
            end
            OPC_BRANCH: begin
                dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
                dec_rd      = 5'd0;
                dec_rs2     = if_instr[24:20];
                dec_imm     = imm_b;
            end
            OPC_LOAD: begin
                dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                dec_imm     = imm_i;
            end
            OPC_STORE: begin
                dec_illegal = (f3 > 3'b010);
                dec_rd      = 5'd0;
                dec_rs2     = if_instr[24:20];
                dec_imm     = imm_s;
            end
            OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    dec_illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                dec_imm = imm_i;
            end
            OPC_OP: begin
                dec_illegal = !((f7 == 7'b0000000) ||
                                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
                dec_rs2     = if_instr[24:20];
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal encodings never carry an immediate, even with a known opcode.
        if (dec_illegal)
            dec_imm = 32'd0;
    end

    always_comb begin
        rs1_val = rf[dec_rs1];
        if (dec_rs1 == 5'd0)
            rs1_val = 32'd0;
        else if (BYPASS_EN && wb_en && (wb_rd == dec_rs1))
            rs1_val = wb_data;
        rs2_val = rf[dec_rs2];
        if (dec_rs2 == 5'd0)
            rs2_val = 32'd0;
        else if (BYPASS_EN && wb_en && (wb_rd == dec_rs2))
            rs2_val = wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (wb_write) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid     <= 1'b0;
            id_pc        <= 32'd0;
            id_instr     <= 32'd0;
            id_opcode    <= 7'd0;
            id_funct3    <= 3'd0;
            id_funct7_b5 <= 1'b0;
            id_rd        <= 5'd0;
            id_rs1       <= 5'd0;
            id_rs2       <= 5'd0;
            id_rs1_data  <= 32'd0;
            id_rs2_data  <= 32'd0;
            id_imm       <= 32'd0;
            id_illegal   <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid     <= 1'b1;
            id_pc        <= if_pc;
            id_instr     <= if_instr;
            id_opcode    <= opc;
            id_funct3    <= f3;
            id_funct7_b5 <= if_instr[30];
            id_rd        <= dec_rd;
            id_rs1       <= dec_rs1;
            id_rs2       <= dec_rs2;
            id_rs1_data  <= rs1_val;
            id_rs2_data  <= rs2_val;
            id_imm       <= dec_imm;
            id_illegal   <= dec_illegal;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end else if (id_valid && wb_write) begin
            // Stalled: keep held operands coherent with the register file.
            if (wb_rd == id_rs1)
                id_rs1_data <= wb_data;
            if (wb_rd == id_rs2)
                id_rs2_data <= wb_data;
        end
    end

endmodule
